// File: rtl/mul8_share_pkg.sv
// Shared types and helpers for the time-multiplexed 8-bit multiplier front end.
package mul8_share_pkg;

  localparam int unsigned MUL_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  // One-hot round-robin pick over the low n bits of valid, searching upward from ptr.
  function automatic logic [7:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input int unsigned n);
    logic [7:0]  g;
    logic        found;
    int unsigned idx;
    g     = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (k < n && !found) begin
        idx = (32'(ptr) + k) % n;
        if (valid[idx[2:0]]) begin
          g[idx[2:0]] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mul8_lo.sv
// Behavioural stand-in for the shared multiplier netlist: low 8 bits of a*b.
module mul8_lo (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  assign y = a * b;

endmodule

// File: rtl/mul8_share_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant plus a registered search pointer.
module rr_arbiter
  import mul8_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               adv,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gidx,
  output logic [ID_W-1:0]    ptr
);

  logic [7:0] pick;

  assign pick  = rr_pick(8'(valid), 3'(ptr), NUM_REQ);
  assign grant = NUM_REQ'(pick);

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gidx = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv && |grant) begin
      ptr <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/mul8_share_arbiter.sv
// Shares one 8x8 low-half multiplier among NUM_REQ requesters with a tagged,
// back-pressured response channel.
module mul8_share_arbiter
  import mul8_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*MUL_W-1:0] req_a,
  input  logic [NUM_REQ*MUL_W-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [MUL_W-1:0]         rsp_y,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_cnt
);

  state_t             state, state_n;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gidx;
  logic [ID_W-1:0]    rr_ptr;
  logic               can_grant;
  logic               take;
  logic [MUL_W-1:0]   a_q, b_q, y;
  logic [ID_W-1:0]    id_q;

  // A new request may be accepted in IDLE, or in RESP in the same cycle the result drains.
  assign can_grant = (state == IDLE) || (state == RESP && rsp_ready);
  assign req_ready = can_grant ? grant : '0;
  assign take      = |req_ready;
  assign busy      = (state != IDLE);

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .valid(req_valid),
    .adv  (can_grant),
    .grant(grant),
    .gidx (gidx),
    .ptr  (rr_ptr)
  );

  mul8_lo u_mul (
    .a(a_q),
    .b(b_q),
    .y(y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (take) state_n = MUL;
      MUL:     state_n = RESP;
      RESP:    if (rsp_ready) state_n = take ? MUL : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      op_cnt    <= '0;
    end else begin
      if (take) begin
        a_q  <= req_a[MUL_W*int'(gidx) +: MUL_W];
        b_q  <= req_b[MUL_W*int'(gidx) +: MUL_W];
        id_q <= gidx;
      end
      if (state == MUL) begin
        rsp_y     <= y;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        op_cnt    <= op_cnt + 1'b1;
      end
    end
  end

endmodule
